// File: rtl/commit_trace_tx.sv
// Commit trace writer: captures retired writebacks and PC redirects into a FIFO and
// serialises each as a 10-byte record on a byte valid/ready stream. Events are dropped when the FIFO is full.
module commit_trace_tx #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DROP_W    = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      trace_enable,
    input  logic                      wb_valid,
    input  logic [31:0]               wb_pc,
    input  logic [4:0]                wb_rd,
    input  logic [31:0]               wb_value,
    input  logic                      br_valid,
    input  logic [31:0]               br_pc,
    input  logic [31:0]               br_target,
    output logic                      out_valid,
    output logic [7:0]                out_data,
    input  logic                      out_ready,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_next;

    logic [69:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [79:0]   shreg;
    logic [3:0]    idx;

    logic          reg_ev, pc_ev, push_ok, drop, pop, shift, accept;
    logic [1:0]    n_ev;
    logic [LW-1:0] free;
    logic [69:0]   reg_entry, pc_entry, head;
    logic [DROP_W:0] drop_sum;

    assign reg_ev    = trace_enable && wb_valid && (wb_rd != 5'd0);
    assign pc_ev     = trace_enable && br_valid;
    assign n_ev      = {1'b0, reg_ev} + {1'b0, pc_ev};
    // Only pre-edge occupancy counts; a same-edge pop gives no credit.
    assign free      = LW'(DEPTH) - fifo_level;
    assign push_ok   = (n_ev != 2'd0) && (free >= LW'(n_ev));
    assign drop      = (n_ev != 2'd0) && !push_ok;
    assign reg_entry = {wb_pc, 1'b0, wb_rd, wb_value};
    assign pc_entry  = {br_pc, 6'd32, br_target};
    assign head      = mem[rd_ptr];
    assign drop_sum  = {1'b0, drop_count} + (DROP_W+1)'(n_ev);

    assign out_valid = (state == SEND);
    assign out_data  = shreg[7:0];
    assign accept    = out_valid && out_ready;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx == 4'd9) begin
                        if (fifo_level != '0) pop = 1'b1;
                        else                  state_next = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reg event occupies the first slot, PC event the slot after it.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            if (reg_ev) mem[wr_ptr] <= reg_entry;
            if (pc_ev)  mem[wr_ptr + AW'(reg_ev)] <= pc_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            shreg      <= '0;
            idx        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state <= state_next;
            if (push_ok) wr_ptr <= wr_ptr + AW'(n_ev);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + (push_ok ? LW'(n_ev) : '0) - LW'(pop);
            if (pop) begin
                shreg <= {head[31:0], 2'b00, head[37:32], head[69:38], SYNC_BYTE};
                idx   <= '0;
            end else if (shift) begin
                shreg <= {8'h00, shreg[79:8]};
                idx   <= idx + 4'd1;
            end
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed self-checking bench for commit_trace_tx: record format, back-to-back records,
// backpressure, overflow/drop counting, mid-record reset and drain with tracing disabled.
module tb_commit_trace_tx;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        trace_enable = 1'b1;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_value = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic [31:0] br_target = '0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;
    logic        overflow;
    logic [15:0] drop_count;
    logic [3:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    commit_trace_tx #(.DEPTH(8), .DROP_W(16), .SYNC_BYTE(8'hA5)) dut (
        .clock(clock), .reset(reset), .trace_enable(trace_enable),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_value(wb_value),
        .br_valid(br_valid), .br_pc(br_pc), .br_target(br_target),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .overflow(overflow), .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_record(input string tag, input logic [31:0] pc, input logic [5:0] tgt,
                                 input logic [31:0] val, input bit must_now);
        logic [79:0] r;
        int unsigned n;
        r = {val, 2'b00, tgt, pc, 8'hA5};
        out_ready = 1'b1;
        if (must_now) check({tag, "_now"}, {31'd0, out_valid}, 32'd1);
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("%s_b%0d", tag, i), {23'd0, out_valid, out_data}, {23'd0, 1'b1, r[8*i +: 8]});
            step();
        end
    endtask

    task automatic wb_event(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val);
        wb_valid = 1'b1; wb_pc = pc; wb_rd = rd; wb_value = val;
    endtask

    initial begin
        logic [79:0] r3;
        int unsigned n;

        // reset state
        #12;
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_data", {24'd0, out_data}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_drop", {16'd0, drop_count}, 0);
        check("rst_level", {28'd0, fifo_level}, 0);
        reset = 1'b1;
        step();

        // 1: single writeback record, latency
        wb_event(32'h10, 5'd5, 32'hDEADBEEF);
        step();
        wb_valid = 1'b0;
        check("t1_e0_valid", {31'd0, out_valid}, 0);
        check("t1_e0_level", {28'd0, fifo_level}, 1);
        step();
        check("t1_e1_valid", {31'd0, out_valid}, 1);
        check("t1_e1_sync", {24'd0, out_data}, 32'hA5);
        expect_record("t1", 32'h10, 6'd5, 32'hDEADBEEF, 1'b1);
        check("t1_idle", {31'd0, out_valid}, 0);

        // 2: dual event, back-to-back; x0 write ignored
        wb_event(32'h20, 5'd1, 32'd8);
        br_valid = 1'b1; br_pc = 32'h20; br_target = 32'h40;
        step();
        wb_valid = 1'b0; br_valid = 1'b0;
        check("t2_level", {28'd0, fifo_level}, 2);
        expect_record("t2_reg", 32'h20, 6'd1, 32'd8, 1'b0);
        expect_record("t2_pc", 32'h20, 6'd32, 32'h40, 1'b1);
        check("t2_idle", {31'd0, out_valid}, 0);
        wb_event(32'h24, 5'd0, 32'h1234);
        step();
        wb_valid = 1'b0;
        step(); step();
        check("t2_x0_level", {28'd0, fifo_level}, 0);
        check("t2_x0_valid", {31'd0, out_valid}, 0);
        check("t2_x0_drop", {16'd0, drop_count}, 0);

        // 3: backpressure mid-record
        wb_event(32'h12345678, 5'd7, 32'h0BADF00D);
        step();
        wb_valid = 1'b0;
        step();
        r3 = {32'h0BADF00D, 8'h07, 32'h12345678, 8'hA5};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_b%0d", i), {23'd0, out_valid, out_data}, {23'd0, 1'b1, r3[8*i +: 8]});
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("t3_hold%0d", i), {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h34});
        end
        out_ready = 1'b1;
        for (int i = 3; i < 10; i++) begin
            check($sformatf("t3_b%0d", i), {23'd0, out_valid, out_data}, {23'd0, 1'b1, r3[8*i +: 8]});
            step();
        end
        check("t3_idle", {31'd0, out_valid}, 0);

        // 4: overflow; one record held in the shifter, then 9 events into an 8-deep FIFO
        out_ready = 1'b0;
        wb_event(32'h100, 5'd2, 32'h1);
        step();
        wb_valid = 1'b0;
        step();
        check("t4_held_level", {28'd0, fifo_level}, 0);
        for (int i = 0; i < 9; i++) begin
            wb_event(32'h200 + 32'(4*i), 5'(i + 1), 32'(i));
            step();
        end
        wb_valid = 1'b0;
        check("t4_level8", {28'd0, fifo_level}, 8);
        check("t4_drop1", {16'd0, drop_count}, 1);
        check("t4_ovf", {31'd0, overflow}, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        out_ready = 1'b0;
        check("t4_level7", {28'd0, fifo_level}, 7);
        wb_event(32'h300, 5'd3, 32'h3);
        br_valid = 1'b1; br_pc = 32'h300; br_target = 32'h400;
        step();
        wb_valid = 1'b0; br_valid = 1'b0;
        check("t4_drop3", {16'd0, drop_count}, 3);
        check("t4_level7b", {28'd0, fifo_level}, 7);
        out_ready = 1'b1;
        n = 0;
        while ((fifo_level != 0 || out_valid) && n < 200) begin
            step();
            n++;
        end
        check("t4_drain_level", {28'd0, fifo_level}, 0);
        check("t4_drain_valid", {31'd0, out_valid}, 0);

        // 5: reset during byte 4
        wb_event(32'hA0, 5'd9, 32'h99);
        step();
        wb_event(32'hA4, 5'd10, 32'hAA);
        step();
        wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t5_pre_valid", {31'd0, out_valid}, 1);
        check("t5_pre_byte4", {24'd0, out_data}, 32'h00);
        check("t5_pre_level", {28'd0, fifo_level}, 1);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, out_valid}, 0);
        check("t5_rst_level", {28'd0, fifo_level}, 0);
        check("t5_rst_drop", {16'd0, drop_count}, 0);
        check("t5_rst_ovf", {31'd0, overflow}, 0);
        step();
        reset = 1'b1;
        step();
        check("t5_post_valid", {31'd0, out_valid}, 0);
        wb_event(32'hB0, 5'd11, 32'hCAFEF00D);
        step();
        wb_valid = 1'b0;
        expect_record("t5", 32'hB0, 6'd11, 32'hCAFEF00D, 1'b0);
        check("t5_idle", {31'd0, out_valid}, 0);

        // 6: drain with tracing disabled
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_event(32'hC0 + 32'(4*i), 5'(12 + i), 32'h5000 + 32'(i));
            step();
        end
        trace_enable = 1'b0;
        wb_event(32'hF0, 5'd13, 32'hFFFF);
        br_valid = 1'b1; br_pc = 32'hF0; br_target = 32'hF00;
        check("t6_level", {28'd0, fifo_level}, 2);
        expect_record("t6_r0", 32'hC0, 6'd12, 32'h5000, 1'b1);
        expect_record("t6_r1", 32'hC4, 6'd13, 32'h5001, 1'b1);
        expect_record("t6_r2", 32'hC8, 6'd14, 32'h5002, 1'b1);
        for (int i = 0; i < 5; i++) step();
        check("t6_idle", {31'd0, out_valid}, 0);
        check("t6_level0", {28'd0, fifo_level}, 0);
        check("t6_drop", {16'd0, drop_count}, 0);
        wb_valid = 1'b0; br_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
